imem_responder: RTL and testbench
=================================

// Module: imem_responder
// PURPOSE
//   Responder end of the instruction-fetch interface: accepts fetch requests (byte PC)
//   from the IF stage and returns 32-bit instruction words after configurable wait states.
//   Holds the instruction store and a program-load write port used by the loader/bench.
//   Sits between the fetch stage and program memory; one request outstanding at a time.
// PARAMETERS
//   PC_WIDTH        6   byte-address width of fetch requests; must be >= CODE_DIR_WIDTH+2
//   CODE_DIR_WIDTH  4   word-index width of the instruction store
//   CODE_DEPTH      16  number of 32-bit words; must be <= 2**CODE_DIR_WIDTH
//   WAIT_STATES     2   extra cycles between accept and response; legal range 0..15
// PORTS
//   clk        in   1               clock, rising edge
//   rst        in   1               asynchronous, active-low reset
//   req_valid  in   1               fetch request valid
//   req_ready  out  1               responder can accept a request this cycle
//   req_addr   in   PC_WIDTH        byte address (PC) of requested instruction
//   rsp_valid  out  1               response valid; held until rsp_ready
//   rsp_ready  in   1               fetch stage accepts the response
//   rsp_instr  out  32              instruction word
//   rsp_addr   out  PC_WIDTH        echo of the accepted req_addr
//   load_en    in   1               program-load write strobe
//   load_addr  in   CODE_DIR_WIDTH  word index to write
//   load_data  in   32              word to write
//   busy       out  1               high in WAIT or RESP
//   rsp_err    out  1               (only with IMEM_ALIGN_CHECK_EN) fetch fault flag
// BEHAVIOUR
//   - Reset (rst=0, async): state IDLE, rsp_valid=0, rsp_instr=0, rsp_addr=0, busy=0,
//     wait counter=0, rsp_err=0. Store contents are NOT cleared by reset.
//   - req_ready = !load_en && (state==IDLE || (state==RESP && rsp_ready)). Combinational.
//   - Accept = req_valid && req_ready. On accept: latch word store[req_addr[CODE_DIR_WIDTH+1:2]]
//     and req_addr. Word index >= CODE_DEPTH, or any req_addr bit above CODE_DIR_WIDTH+1
//     set -> latched word is NOP 32'h0000_0000.
//   - Data is sampled at accept; a load to the same word after accept does not alter the
//     pending response.
//   - FSM: IDLE -accept-> WAIT (WAIT_STATES>0, counter=WAIT_STATES-1) or RESP (WAIT_STATES=0).
//     WAIT: counter decrements each cycle; at 0 -> RESP.
//     RESP: rsp_valid=1, rsp_instr/rsp_addr stable until rsp_ready=1.
//     On rsp_ready: if accept same cycle -> WAIT/RESP for the new request (back-to-back),
//     else -> IDLE.
//   - Latency: accept at cycle N -> rsp_valid first high at N+1+WAIT_STATES.
//     WAIT_STATES=0 with rsp_ready tied high gives one instruction per cycle.
//   - load_en: synchronous write store[load_addr]<=load_data in any state. load_addr >= CODE_DEPTH
//     is ignored. load_en=1 forces req_ready=0 (load wins a simultaneous request).
//     An in-flight response is unaffected.
//   - rsp_valid never drops without rsp_ready; rsp_ready outside RESP is ignored.
// CONFIGURATION
//   IMEM_ALIGN_CHECK_EN defined: rsp_err port present; with rsp_valid, rsp_err=1 when
//     accepted req_addr[1:0]!=0 or address out of range; rsp_instr=0 in that case.
//     Timing is unchanged.
//   Undefined: no rsp_err port; req_addr[1:0] ignored; out-of-range silently returns NOP.
// STRUCTURE
//   Package imem_pkg: state enum {IDLE, WAIT, RESP}, NOP_INSTR=32'h0000_0000,
//     WAIT_CNT_W=4.
//   Sub-module imem_array: CODE_DEPTH x 32 store, sync write port, async read port.
//   FSM, wait counter and response registers live in imem_responder.
// TESTING
//   1 Reset mid-WAIT (rst=0 while busy=1) -> rsp_valid=0, busy=0, req_ready=1 after release;
//     the store keeps its contents.
//   2 Load word 3 = 32'h2002_0005.
//     Fetch req_addr=6'h0C at cycle N with WAIT_STATES=2 -> rsp_valid at N+3,
//     rsp_instr=32'h2002_0005, rsp_addr=6'h0C.
//   3 WAIT_STATES=0, rsp_ready=1, req_valid=1 with addrs 0,4,8,C -> one response per cycle,
//     in order, no bubbles.
//   4 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_instr, rsp_addr
//     held stable; req_ready=0.
//   5 load_en=1 together with req_valid=1 -> req_ready=0 and the write lands.
//     Load word 3 = 32'hFFFF_FFFF during WAIT of a fetch to 0x0C -> response keeps the old word.
//   6 req_addr=6'h3C with CODE_DEPTH=12 -> rsp_instr=0.
//     With IMEM_ALIGN_CHECK_EN: req_addr=6'h06 -> rsp_err=1, rsp_instr=0.

Source files
------------

// File: rtl/imem_pkg.sv
//------------------------------------------------------------------------------
// Module   : imem_pkg
// Purpose  : Shared types and constants for the instruction-fetch responder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam int          WAIT_CNT_W = 4;

endpackage : imem_pkg

`default_nettype wire

// File: rtl/imem_array.sv
//------------------------------------------------------------------------------
// Module   : imem_array
// Purpose  : CODE_DEPTH x 32 instruction store, synchronous write / async read.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module imem_array
    import imem_pkg::*;
#(
    parameter int CODE_DIR_WIDTH = 4,
    parameter int CODE_DEPTH     = 16
) (
    input  logic                      clk,
    input  logic                      wr_en,
    input  logic [CODE_DIR_WIDTH-1:0] wr_addr,
    input  logic [31:0]               wr_data,
    input  logic [CODE_DIR_WIDTH-1:0] rd_addr,
    output logic [31:0]               rd_data
);

    logic [31:0] r_mem [CODE_DEPTH];
    logic        w_wr_ok;
    logic        w_rd_ok;

    // Indices past the populated depth are never written and read back as NOP.
    assign w_wr_ok = ({1'b0, wr_addr} < (CODE_DIR_WIDTH+1)'(CODE_DEPTH));
    assign w_rd_ok = ({1'b0, rd_addr} < (CODE_DIR_WIDTH+1)'(CODE_DEPTH));

    always_ff @(posedge clk) begin
        if (wr_en && w_wr_ok) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = w_rd_ok ? r_mem[rd_addr] : NOP_INSTR;

endmodule : imem_array

`default_nettype wire

// File: rtl/imem_responder.sv
//------------------------------------------------------------------------------
// Module   : imem_responder
// Purpose  : Instruction-fetch responder: one outstanding request, returns the
//            addressed word after WAIT_STATES cycles. Optional fetch-fault
//            reporting is enabled with the IMEM_ALIGN_CHECK_EN macro.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module imem_responder
    import imem_pkg::*;
#(
    parameter int PC_WIDTH       = 6,
    parameter int CODE_DIR_WIDTH = 4,
    parameter int CODE_DEPTH     = 16,
    parameter int WAIT_STATES    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [PC_WIDTH-1:0]       req_addr,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [31:0]               rsp_instr,
    output logic [PC_WIDTH-1:0]       rsp_addr,
    input  logic                      load_en,
    input  logic [CODE_DIR_WIDTH-1:0] load_addr,
    input  logic [31:0]               load_data,
`ifdef IMEM_ALIGN_CHECK_EN
    output logic                      rsp_err,
`endif
    output logic                      busy
);

    localparam logic [WAIT_CNT_W-1:0] c_WAIT_INIT =
        (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

    state_t                    r_state;
    logic [WAIT_CNT_W-1:0]     r_wait_cnt;
    logic                      r_rsp_valid;
    logic [31:0]               r_rsp_instr;
    logic [PC_WIDTH-1:0]       r_rsp_addr;

    logic [CODE_DIR_WIDTH-1:0] w_word_idx;
    logic [31:0]               w_rd_data;
    logic                      w_hi_set;
    logic                      w_in_range;
    logic                      w_accept;
    logic [31:0]               w_fetch_word;

    assign w_word_idx = req_addr[CODE_DIR_WIDTH+1:2];

    imem_array #(
        .CODE_DIR_WIDTH (CODE_DIR_WIDTH),
        .CODE_DEPTH     (CODE_DEPTH)
    ) u_imem_array (
        .clk     (clk),
        .wr_en   (load_en),
        .wr_addr (load_addr),
        .wr_data (load_data),
        .rd_addr (w_word_idx),
        .rd_data (w_rd_data)
    );

    // PC bits above the store's word index make the fetch out of range.
    generate
        if (PC_WIDTH > CODE_DIR_WIDTH + 2) begin : g_hi_bits
            assign w_hi_set = |req_addr[PC_WIDTH-1:CODE_DIR_WIDTH+2];
        end else begin : g_no_hi_bits
            assign w_hi_set = 1'b0;
        end
    endgenerate

    assign w_in_range = !w_hi_set &&
                        ({1'b0, w_word_idx} < (CODE_DIR_WIDTH+1)'(CODE_DEPTH));

    assign req_ready = !load_en &&
                       ((r_state == IDLE) || ((r_state == RESP) && rsp_ready));
    assign w_accept  = req_valid && req_ready;

`ifdef IMEM_ALIGN_CHECK_EN
    logic w_fetch_err;
    logic r_rsp_err;

    assign w_fetch_err  = (req_addr[1:0] != 2'b00) || !w_in_range;
    assign w_fetch_word = w_fetch_err ? NOP_INSTR : w_rd_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rsp_err <= 1'b0;
        end else if (w_accept) begin
            r_rsp_err <= w_fetch_err;
        end
    end

    assign rsp_err = r_rsp_err;
`else
    assign w_fetch_word = w_in_range ? w_rd_data : NOP_INSTR;
`endif

    // Word and address are captured at accept so later loads cannot disturb them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_wait_cnt  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_instr <= NOP_INSTR;
            r_rsp_addr  <= '0;
        end else if (w_accept) begin
            r_rsp_instr <= w_fetch_word;
            r_rsp_addr  <= req_addr;
            if (WAIT_STATES == 0) begin
                r_state     <= RESP;
                r_rsp_valid <= 1'b1;
            end else begin
                r_state     <= WAIT;
                r_wait_cnt  <= c_WAIT_INIT;
                r_rsp_valid <= 1'b0;
            end
        end else begin
            case (r_state)
                WAIT: begin
                    if (r_wait_cnt == '0) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_instr = r_rsp_instr;
    assign rsp_addr  = r_rsp_addr;
    assign busy      = (r_state != IDLE);

endmodule : imem_responder

`default_nettype wire

// File: tb/tb_imem_responder.sv
//------------------------------------------------------------------------------
// Module   : tb_imem_responder
// Purpose  : Self-checking bench; instance 0 has 2 wait states and 12 words,
//            instance 1 has no wait states and 16 words.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_imem_responder;

    localparam int c_WS[2]    = '{2, 0};
    localparam int c_DEPTH[2] = '{12, 16};

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [5:0]  req_addr  [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_instr [2];
    logic [5:0]  rsp_addr  [2];
    logic        load_en   [2];
    logic [3:0]  load_addr [2];
    logic [31:0] load_data [2];
    logic        busy      [2];
`ifdef IMEM_ALIGN_CHECK_EN
    logic        rsp_err   [2];
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: word store, outstanding flag, accept cycle, expected response.
    logic [31:0] mdl_mem [2][16];
    bit          m_out   [2];
    int          m_tacc  [2];
    logic [31:0] m_instr [2];
    logic [5:0]  m_addr  [2];
    logic        m_err   [2];
    int          cyc = 0;

    always #5 clk = ~clk;

    imem_responder #(.PC_WIDTH(6), .CODE_DIR_WIDTH(4), .CODE_DEPTH(12), .WAIT_STATES(2)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_instr(rsp_instr[0]),
        .rsp_addr(rsp_addr[0]), .load_en(load_en[0]), .load_addr(load_addr[0]),
        .load_data(load_data[0]),
`ifdef IMEM_ALIGN_CHECK_EN
        .rsp_err(rsp_err[0]),
`endif
        .busy(busy[0])
    );

    imem_responder #(.PC_WIDTH(6), .CODE_DIR_WIDTH(4), .CODE_DEPTH(16), .WAIT_STATES(0)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_instr(rsp_instr[1]),
        .rsp_addr(rsp_addr[1]), .load_en(load_en[1]), .load_addr(load_addr[1]),
        .load_data(load_data[1]),
`ifdef IMEM_ALIGN_CHECK_EN
        .rsp_err(rsp_err[1]),
`endif
        .busy(busy[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // What a fetch of byte address a on instance i must return.
    task automatic predict(input int i, input logic [5:0] a);
        int  idx;
        bit  in_range;
        idx      = int'(a) / 4;
        in_range = (idx < c_DEPTH[i]);
`ifdef IMEM_ALIGN_CHECK_EN
        m_err[i]   = (int'(a) % 4 != 0) || !in_range;
        m_instr[i] = m_err[i] ? 32'h0 : mdl_mem[i][idx];
`else
        m_err[i]   = 1'b0;
        m_instr[i] = in_range ? mdl_mem[i][idx] : 32'h0;
`endif
        m_addr[i] = a;
    endtask

    // One clock: check outputs at the negedge, then advance the model at the posedge.
    task automatic tick();
        bit acc [2];
        bit hs  [2];
        bit ev, er;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!rst) m_out[i] = 1'b0;
            ev = m_out[i] && (cyc >= m_tacc[i] + 1 + c_WS[i]);
            er = !load_en[i] && (!m_out[i] || (ev && rsp_ready[i]));
            chk($sformatf("i%0d_rsp_valid@%0d", i, cyc), rsp_valid[i], ev);
            chk($sformatf("i%0d_req_ready@%0d", i, cyc), req_ready[i], er);
            chk($sformatf("i%0d_busy@%0d", i, cyc), busy[i], m_out[i]);
            if (ev) begin
                chk($sformatf("i%0d_rsp_instr@%0d", i, cyc), rsp_instr[i], m_instr[i]);
                chk($sformatf("i%0d_rsp_addr@%0d", i, cyc), rsp_addr[i], m_addr[i]);
`ifdef IMEM_ALIGN_CHECK_EN
                chk($sformatf("i%0d_rsp_err@%0d", i, cyc), rsp_err[i], m_err[i]);
`endif
            end
            acc[i] = rst && req_valid[i] && er;
            hs[i]  = rst && ev && rsp_ready[i];
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (hs[i]) m_out[i] = 1'b0;
            if (acc[i]) begin
                predict(i, req_addr[i]);
                m_out[i]  = 1'b1;
                m_tacc[i] = cyc;
            end
            if (load_en[i] && int'(load_addr[i]) < c_DEPTH[i])
                mdl_mem[i][load_addr[i]] = load_data[i];
        end
        cyc++;
        #1;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_addr[i]  = '0; rsp_ready[i] = 1'b0;
            load_en[i]   = 1'b0; load_addr[i] = '0; load_data[i] = '0;
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_out[i] = 1'b0; m_tacc[i] = 0; m_instr[i] = '0; m_addr[i] = '0; m_err[i] = 1'b0;
            for (int k = 0; k < 16; k++) mdl_mem[i][k] = '0;
        end
        idle_inputs();
        rst = 1'b0;
        tick(); tick();
        chk("reset_rsp_instr", rsp_instr[0], 32'h0);
        chk("reset_rsp_addr", rsp_addr[0], 32'h0);
        rst = 1'b1;
        tick();

        // Preload every word of both stores.
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 2; i++) begin
                load_en[i] = 1'b1; load_addr[i] = 4'(k); load_data[i] = $urandom;
            end
            tick();
        end
        idle_inputs();

        // Word 3 fetch with two wait states, then five cycles of backpressure.
        load_en[0] = 1'b1; load_addr[0] = 4'd3; load_data[0] = 32'h2002_0005;
        tick();
        load_en[0] = 1'b0;
        req_valid[0] = 1'b1; req_addr[0] = 6'h0C;
        tick();
        req_valid[0] = 1'b0;
        tick(); tick();
        chk("lat_valid", rsp_valid[0], 1'b1);
        chk("lat_instr", rsp_instr[0], 32'h2002_0005);
        chk("lat_addr", rsp_addr[0], 32'h0C);
        for (int k = 0; k < 5; k++) tick();
        chk("bp_ready", req_ready[0], 1'b0);
        chk("bp_instr", rsp_instr[0], 32'h2002_0005);
        rsp_ready[0] = 1'b1;
        tick();

        // Reset in the middle of a wait period; the store survives.
        req_valid[0] = 1'b1; req_addr[0] = 6'h08;
        tick();
        req_valid[0] = 1'b0;
        chk("pre_rst_busy", busy[0], 1'b1);
        rst = 1'b0;
        #1;
        chk("rst_busy", busy[0], 1'b0);
        chk("rst_valid", rsp_valid[0], 1'b0);
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_ready", req_ready[0], 1'b1);
        req_valid[0] = 1'b1; req_addr[0] = 6'h0C;
        tick();
        req_valid[0] = 1'b0;
        for (int k = 0; k < 3; k++) tick();

        // Load beats a simultaneous request; a later load leaves the pending word alone.
        load_en[0] = 1'b1; load_addr[0] = 4'd5; load_data[0] = 32'hABCD_1234;
        req_valid[0] = 1'b1; req_addr[0] = 6'h14;
        tick();
        load_en[0] = 1'b0;
        tick();
        req_addr[0] = 6'h0C;
        for (int k = 0; k < 3; k++) tick();
        req_valid[0] = 1'b0;
        load_en[0] = 1'b1; load_addr[0] = 4'd3; load_data[0] = 32'hFFFF_FFFF;
        tick();
        load_en[0] = 1'b0;
        tick(); tick();
        chk("load_during_wait", rsp_instr[0], 32'h2002_0005);
        tick();

        // Out-of-range word on the 12-deep store.
        req_valid[0] = 1'b1; req_addr[0] = 6'h3C;
        tick();
        req_valid[0] = 1'b0;
        tick(); tick();
        chk("oob_instr", rsp_instr[0], 32'h0);
        tick();
`ifdef IMEM_ALIGN_CHECK_EN
        req_valid[0] = 1'b1; req_addr[0] = 6'h06;
        tick();
        req_valid[0] = 1'b0;
        tick(); tick();
        chk("misalign_err", rsp_err[0], 1'b1);
        chk("misalign_instr", rsp_instr[0], 32'h0);
        tick();
`endif

        // Zero wait states: one response per cycle.
        rsp_ready[1] = 1'b1; req_valid[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_addr[1] = 6'(4 * k);
            tick();
            chk("stream_valid", rsp_valid[1], 1'b1);
            chk("stream_addr", rsp_addr[1], 32'(4 * k));
        end
        req_valid[1] = 1'b0;
        tick();

        // Randomized traffic on both instances.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                req_valid[i] = 1'($urandom_range(0, 1));
                req_addr[i]  = 6'($urandom);
                rsp_ready[i] = ($urandom_range(0, 3) != 0);
                load_en[i]   = ($urandom_range(0, 7) == 0);
                load_addr[i] = 4'($urandom);
                load_data[i] = $urandom;
            end
            tick();
        end
        idle_inputs();
        rsp_ready[0] = 1'b1; rsp_ready[1] = 1'b1;
        for (int k = 0; k < 6; k++) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_imem_responder

`default_nettype wire
